// File: rtl/pipe_stage_buf.sv
// DEPTH-entry elastic pipeline stage with valid/ready handshake, synchronous flush and NOP bubbles.
// Optional `PIPE_CUT_THROUGH_EN: an empty buffer forwards in_data to out_data in the same cycle.
module pipe_stage_buf #(
   parameter int unsigned          PAYLOAD_W = 110,
   parameter int unsigned          DEPTH     = 2,
   parameter logic [PAYLOAD_W-1:0] NOP_VALUE = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [PAYLOAD_W-1:0]     in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PAYLOAD_W-1:0]     out_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned      PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

   logic [PAYLOAD_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]       count_q, count_d;
   logic                 up_q;
   logic                 stored_valid;
   logic                 push, pop;

   // in_ready is held low through reset and rises on the first edge after release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         up_q     <= 1'b0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         up_q     <= 1'b1;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
   end

   always_comb begin
      in_ready     = up_q && (count_q != CNT_FULL) && !flush;
      stored_valid = (count_q != '0) && !flush;
      pop          = stored_valid && out_ready;
`ifdef PIPE_CUT_THROUGH_EN
      // Empty buffer forwards the input; a consumed forward bypasses storage entirely.
      out_valid = stored_valid || (up_q && (count_q == '0) && !flush && in_valid);
      out_data  = stored_valid ? mem_q[rd_ptr_q] : (out_valid ? in_data : NOP_VALUE);
      push      = in_valid && in_ready && !(!stored_valid && out_valid && out_ready);
`else
      out_valid = stored_valid;
      out_data  = stored_valid ? mem_q[rd_ptr_q] : NOP_VALUE;
      push      = in_valid && in_ready;
`endif
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   assign count = count_q;

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised successor to the fixed EX→MEM pipeline latch: a DEPTH-entry elastic pipeline stage carrying a packed payload between two pipeline stages with a valid/ready handshake, synchronous flush and NOP-bubble output. It replaces ad-hoc stall-vector registers between ID/EX, EX/MEM and MEM/WB. The upstream stage stalls only when the buffer is full, so no combinational path runs from downstream stall to upstream stall.

## Interface
- PAYLOAD_W, 110, payload width in bits. The default packs wd[5] | wreg[1] | wdata[32] | aluop[8] | mem_addr[32] | reg2[32], MSB first.
- DEPTH, 2, number of storage entries. Must be a power of two and ≥2.
- NOP_VALUE, {PAYLOAD_W{1'b0}}, payload driven on out_data whenever out_valid=0. The all-zero value encodes NOPRegAddr, WriteDisable and EXE_NOP_OP.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- flush  in  1  synchronous discard of all buffered entries.
- in_valid  in  1  upstream presents a payload.
- in_ready  out  1  buffer can accept; a push happens when in_valid && in_ready.
- in_data  in  PAYLOAD_W  upstream payload.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes; a pop happens when out_valid && out_ready.
- out_data  out  PAYLOAD_W  head payload, or NOP_VALUE when out_valid=0.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- Storage: circular buffer with rd_ptr/wr_ptr of $clog2(DEPTH) bits each. Pointers wrap modulo DEPTH naturally. Occupancy is held in count.
- in_ready = (count != DEPTH) && !flush. It is registered state only and never depends on out_ready.
- out_valid = (count != 0) && !flush.
- out_data = mem[rd_ptr] when out_valid, else NOP_VALUE. Downstream therefore always sees a bubble, never stale data.
- Push: write in_data to mem[wr_ptr], then wr_ptr+1.
- Pop: rd_ptr+1.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged.
- Full (count=DEPTH): no push is possible, even if a pop happens in the same cycle. A slot frees on the next cycle.
- Empty: no pop is possible. A push into an empty buffer becomes visible on the next cycle.
- Flush has priority over push and pop. On the next edge, rd_ptr, wr_ptr and count all go to 0. The payload in the flush cycle is dropped.
- Storage array is not reset. Its contents are masked by out_valid.

## Timing
- Reset (rst=0, asynchronous), while held:
  - count=0, rd_ptr=0, wr_ptr=0.
  - out_valid=0, out_data=NOP_VALUE, in_ready=0.
- After rst rises: in_ready=1 in the first cycle.
- Reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.
- Latency: payload pushed at edge N appears on out_data during the cycle after edge N, i.e. 1 cycle, same as the legacy latch.
- Throughput: 1 payload/cycle when both sides are ready and count ≥1.
- After a flush edge: out_valid=0 and in_ready=1 in the following cycle.

## Configuration
- PIPE_CUT_THROUGH_EN: when defined, an empty buffer passes data straight through in the same cycle:
  - When count=0, !flush and in_valid: out_valid=1 and out_data=in_data combinationally.
  - If out_ready is also high, the payload is consumed without being stored: no pointer or count change.
  - If out_ready is low, the payload is stored as a normal push.
  - Latency drops to 0 cycles when empty.
  - in_ready is unchanged and still independent of out_ready.
- When PIPE_CUT_THROUGH_EN is undefined: always 1-cycle latency; out_valid depends only on count and flush.

## Test plan
- Reset: hold rst=0 with in_valid=1 and in_data=0xAA… → out_valid=0, out_data=0, in_ready=0, count=0. Release → in_ready=1 on the next cycle.
- Streaming: DEPTH=2, out_ready=1, push 0x1,0x2,0x3 on consecutive cycles → out_data 0x1,0x2,0x3 on cycles 1,2,3; count stays ≤1.
- Backpressure/full: out_ready=0, push 0x5,0x6 → count=2, in_ready=0. A third in_valid is ignored. Raise out_ready → 0x5 then 0x6, in_ready=1 one cycle after the first pop.
- Flush: count=2, assert flush with in_valid=1 and out_ready=1 → out_valid=0 in the flush cycle; next cycle count=0, no entry consumed or stored.
- Wrap-around: DEPTH=4, 10 push/pop pairs with values 0..9 and out_ready toggling every cycle → output order 0..9 exact, no duplication or loss.
- Cut-through (PIPE_CUT_THROUGH_EN defined): empty buffer, in_valid=1, in_data=0x7, out_ready=1 → out_data=0x7 in the same cycle and count stays 0. With out_ready=0 → count=1 next cycle.
